// File: rtl/arf_out_collector.sv
// arf_out_collector: pull-side collector for one arf output port.
// Requests tokens with o_req, captures one token per rising edge of i_ack,
// buffers them in a first-word-fall-through FIFO and presents them on a
// valid/ready stream.
// Optional statistics counters: define ARF_OUT_COLLECTOR_STATS_EN.
module arf_out_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  output logic                        o_req,
  input  logic                        i_ack,
  input  logic [DATA_WIDTH-1:0]       i_din,
  output logic                        o_m_valid,
  input  logic                        i_m_ready,
  output logic [DATA_WIDTH-1:0]       o_m_data,
  output logic [$clog2(DEPTH):0]      o_level,
  output logic                        o_overflow,
  output logic [31:0]                 o_tok_count,
  output logic [31:0]                 o_stall_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [LW-1:0]         r_level;
  logic                  r_ack_d;
  logic                  r_req;
  logic                  r_overflow;

  logic                  w_capture, w_pop, w_full, w_push, w_drop;
  logic [LW-1:0]         w_level_nxt;

  // A token is one rising edge of ack; a held ack counts once.
  assign w_capture = i_ack & ~r_ack_d;
  assign w_pop     = (r_level != '0) & i_m_ready;
  assign w_full    = (r_level == LW'(DEPTH));
  // At full, a same-cycle pop frees the head slot, so the push still lands.
  assign w_push    = w_capture & (~w_full | w_pop);
  assign w_drop    = w_capture & w_full & ~w_pop;

  // Next occupancy: push and pop together leave the level unchanged.
  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)      w_level_nxt = r_level + LW'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LW'(1);
  end

  // FIFO storage, pointers, level, request and overflow state.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_ack_d    <= 1'b0;
      r_req      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ack_d <= i_ack;
      if (w_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_level <= w_level_nxt;
      // Keep one slot free for the token already in flight from arf.
      r_req   <= (w_level_nxt <= LW'(DEPTH - 2));
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign o_req      = r_req;
  assign o_m_valid  = (r_level != '0);
  assign o_m_data   = r_mem[r_rptr];
  assign o_level    = r_level;
  assign o_overflow = r_overflow;

`ifdef ARF_OUT_COLLECTOR_STATS_EN
  logic [31:0] r_tok_count, r_stall_count;

  // Free-running, wrapping statistics counters.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_tok_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_pop) r_tok_count <= r_tok_count + 32'd1;
      if (o_m_valid && !i_m_ready) r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign o_tok_count   = r_tok_count;
  assign o_stall_count = r_stall_count;
`else
  assign o_tok_count   = '0;
  assign o_stall_count = '0;
`endif
endmodule

// File: tb/tb_arf_out_collector.sv
// Directed bench for arf_out_collector (DEPTH=4, DATA_WIDTH=32).
module tb_arf_out_collector;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] din = '0;
  logic        m_ready = 1'b0;
  logic        req, m_valid, overflow;
  logic [31:0] m_data, tok_count, stall_count;
  logic [2:0]  level;

  int checks = 0;
  int failures = 0;

`ifdef ARF_OUT_COLLECTOR_STATS_EN
  localparam logic [31:0] EXP_TOK100 = 32'd100;
`else
  localparam logic [31:0] EXP_TOK100 = 32'd0;
`endif

  arf_out_collector #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .o_req(req), .i_ack(ack), .i_din(din),
    .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data),
    .o_level(level), .o_overflow(overflow),
    .o_tok_count(tok_count), .o_stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One well-formed ack pulse: high for one cycle, then low for one.
  task automatic send(input logic [31:0] v);
    ack = 1'b1; din = v; step();
    ack = 1'b0;          step();
  endtask

  task automatic do_reset();
    rst = 1'b0; ack = 1'b0; m_ready = 1'b0; step();
    rst = 1'b1; step();
  endtask

  initial begin
    // Reset state
    rst = 1'b0; step(); step();
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_level", {29'd0, level}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_tok", tok_count, 32'd0);
    chk("rst_stall", stall_count, 32'd0);
    rst = 1'b1; step();
    chk("first_req", {31'd0, req}, 32'd1);

    // Reset then fill with 0,1,2 while downstream stalls
    for (int i = 0; i < 3; i++) send(i);
    chk("fill_level", {29'd0, level}, 32'd3);
    chk("fill_req", {31'd0, req}, 32'd0);
    chk("fill_ovf", {31'd0, overflow}, 32'd0);
    chk("fill_head", m_data, 32'd0);

    // Full throughput, 100 tokens
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      ack = 1'b1; din = k; step();
      chk("tp_valid", {31'd0, m_valid}, 32'd1);
      chk("tp_data", m_data, k);
      ack = 1'b0; step();
      chk("tp_empty", {31'd0, m_valid}, 32'd0);
    end
    chk("tp_tok", tok_count, EXP_TOK100);
    chk("tp_req", {31'd0, req}, 32'd1);
    chk("tp_ovf", {31'd0, overflow}, 32'd0);

    // Held ack counts once
    m_ready = 1'b0;
    ack = 1'b1; din = 32'd7;
    step(); step(); step();
    ack = 1'b0; step();
    chk("held_level", {29'd0, level}, 32'd1);
    chk("held_data", m_data, 32'd7);

    // Forced overflow: five tokens into a four-entry FIFO
    do_reset();
    for (int i = 0; i < 3; i++) send(i);
    chk("ovf_req_drop", {31'd0, req}, 32'd0);
    send(3);
    chk("ovf_full_level", {29'd0, level}, 32'd4);
    chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
    send(4);
    chk("ovf_level", {29'd0, level}, 32'd4);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", m_data, i);
      step();
    end
    chk("ovf_empty", {31'd0, m_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("ovf_req_back", {31'd0, req}, 32'd1);

    // Simultaneous push and pop at full
    do_reset();
    chk("sim_ovf_clr", {31'd0, overflow}, 32'd0);
    for (int i = 10; i < 14; i++) send(i);
    chk("sim_full", {29'd0, level}, 32'd4);
    ack = 1'b1; din = 32'd14; m_ready = 1'b1; step();
    ack = 1'b0; m_ready = 1'b0;
    chk("sim_level", {29'd0, level}, 32'd4);
    chk("sim_ovf", {31'd0, overflow}, 32'd0);
    chk("sim_head", m_data, 32'd11);
    step();
    m_ready = 1'b1;
    for (int i = 11; i < 15; i++) begin
      chk("sim_drain", m_data, i);
      step();
    end
    chk("sim_empty", {31'd0, m_valid}, 32'd0);

    // Reset mid-stream at level 2
    do_reset();
    send(20); send(21);
    chk("mid_level", {29'd0, level}, 32'd2);
    rst = 1'b0; step();
    chk("mid_req", {31'd0, req}, 32'd0);
    chk("mid_valid", {31'd0, m_valid}, 32'd0);
    chk("mid_data", m_data, 32'd0);
    chk("mid_lvl0", {29'd0, level}, 32'd0);
    chk("mid_stall", stall_count, 32'd0);
    chk("mid_tok", tok_count, 32'd0);
    rst = 1'b1; step();
    chk("mid_req1", {31'd0, req}, 32'd1);
    send(30);
    chk("mid_new_data", m_data, 32'd30);
    chk("mid_new_level", {29'd0, level}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
